// File: rtl/mult_share_arbiter_pkg.sv
// Shared types, limits and the saturating multiply used by the multiplier-sharing block.
package mult_pkg;

  // Default operand/result width and the internal calculation width.
  // Any operand width up to CALC_W-1 is supported by sat_mul.
  localparam int MULT_W = 8;
  localparam int CALC_W = 32;

  // Clamp limits for the default width.
  localparam logic signed [MULT_W-1:0] SAT_MAX = {1'b0, {(MULT_W-1){1'b1}}};
  localparam logic signed [MULT_W-1:0] SAT_MIN = {1'b1, {(MULT_W-1){1'b0}}};

  // Return value of sat_mul: clamp flag plus the (sign-extended) result.
  typedef struct packed {
    logic                     sat;
    logic signed [CALC_W-1:0] result;
  } sat_res_t;

  // Largest representable value of a w-bit signed number, at product width.
  function automatic logic signed [2*CALC_W-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest representable value of a w-bit signed number, at product width.
  function automatic logic signed [2*CALC_W-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Full-precision signed product clamped to the w-bit signed range.
  // Operands are expected to be sign-extended w-bit values.
  function automatic sat_res_t sat_mul(input logic signed [CALC_W-1:0] a,
                                       input logic signed [CALC_W-1:0] b,
                                       input int                       w);
    logic signed [2*CALC_W-1:0] a_x;
    logic signed [2*CALC_W-1:0] b_x;
    logic signed [2*CALC_W-1:0] p;
    logic signed [2*CALC_W-1:0] hi;
    logic signed [2*CALC_W-1:0] lo;
    sat_res_t                   r;
    a_x = {{CALC_W{a[CALC_W-1]}}, a};
    b_x = {{CALC_W{b[CALC_W-1]}}, b};
    p   = a_x * b_x;
    hi  = sat_max(w);
    lo  = sat_min(w);
    if (p > hi) begin
      r.sat    = 1'b1;
      r.result = hi[CALC_W-1:0];
    end else if (p < lo) begin
      r.sat    = 1'b1;
      r.result = lo[CALC_W-1:0];
    end else begin
      r.sat    = 1'b0;
      r.result = p[CALC_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from ptr upwards modulo NUM_REQ and keep the first hit.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        idx      = IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// One saturating signed multiplier shared round-robin among NUM_REQ requesters,
// with a single registered response slot and a saturation event counter.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter  int bitWidth = MULT_W,
  parameter  int NUM_REQ  = 4,
  parameter  int CNT_W    = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*bitWidth-1:0]   req_a,
  input  logic [NUM_REQ*bitWidth-1:0]   req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic signed [bitWidth-1:0]    rsp_result,
  output logic                          rsp_sat,
  output logic [CNT_W-1:0]              sat_count,
  input  logic                          sat_clr
);

  typedef struct packed {
    logic [ID_W-1:0]            id;
    logic signed [bitWidth-1:0] result;
    logic                       sat;
  } rsp_t;

  logic [ID_W-1:0]            rr_ptr;
  logic [NUM_REQ-1:0]         grant_oh;
  logic [ID_W-1:0]            gidx;
  logic                       gany;
  logic                       slot_free;
  logic                       grant_en;
  logic signed [bitWidth-1:0] a_p0;
  logic signed [bitWidth-1:0] b_p0;
  sat_res_t                   prod_p0;
  rsp_t                       rsp_p0;
  logic                       unused_hi;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant_oh),
    .idx   (gidx),
    .any   (gany)
  );

  // Grant only when the response slot can take a result this cycle.
  always_comb begin
    slot_free = !rsp_valid || rsp_ready;
    grant_en  = gany && slot_free && !rst;
    req_ready = grant_en ? grant_oh : '0;
  end

  // Stage p0: select the granted operands and form the clamped product.
  always_comb begin
    a_p0          = req_a[gidx*bitWidth +: bitWidth];
    b_p0          = req_b[gidx*bitWidth +: bitWidth];
    prod_p0       = sat_mul(CALC_W'(a_p0), CALC_W'(b_p0), bitWidth);
    rsp_p0.id     = gidx;
    rsp_p0.result = prod_p0.result[bitWidth-1:0];
    rsp_p0.sat    = prod_p0.sat;
  end

  // Upper result bits are pure sign extension of the clamped value.
  assign unused_hi = ^prod_p0.result[CALC_W-1:bitWidth];

  // Advance the round-robin pointer past each granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_en) begin
      rr_ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Stage p1: response register; loads on grant, drains when free and idle, holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_sat    <= 1'b0;
    end else if (grant_en) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= rsp_p0.id;
      rsp_result <= rsp_p0.result;
      rsp_sat    <= rsp_p0.sat;
    end else if (slot_free) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Count saturated responses taken downstream; clear wins, no wrap.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_count <= '0;
    end else if (rsp_valid && rsp_ready && rsp_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (bitWidth=8, NUM_REQ=4; second instance with CNT_W=2).
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_ready;
  logic        sat_clr;

  logic [3:0]  req_ready, req_ready2;
  logic        rsp_valid, rsp_valid2;
  logic [1:0]  rsp_id, rsp_id2;
  logic [7:0]  rsp_result, rsp_result2;
  logic        rsp_sat, rsp_sat2;
  logic [15:0] sat_count;
  logic [1:0]  sat_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.bitWidth(8), .NUM_REQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_sat(rsp_sat),
    .sat_count(sat_count), .sat_clr(sat_clr)
  );

  mult_share_arbiter #(.bitWidth(8), .NUM_REQ(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id2), .rsp_result(rsp_result2), .rsp_sat(rsp_sat2),
    .sat_count(sat_count2), .sat_clr(sat_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; sat_clr = 1'b0;
    req_a = 32'h04030201; req_b = 32'h05050505;
    repeat (3) tick();
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=%b", req_ready, 4'b0000); end
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++;
    if (sat_count !== 16'd0) begin failures++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
    checks++;
    if (rsp_id !== 2'd0 || rsp_result !== 8'd0 || rsp_sat !== 1'b0) begin
      failures++; $display("FAIL reset_rsp_fields got=%0d/%0h/%b exp=0/0/0", rsp_id, rsp_result, rsp_sat);
    end
    rst = 1'b0; req_valid = 4'h0;
    tick();
  endtask

  task automatic test_single();
    set_lane(2, 8'd5, 8'hF9);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=%b", req_ready, 4'b0100); end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 8'hDD || rsp_sat !== 1'b0) begin
      failures++; $display("FAIL single_rsp got=%b/%0d/%0h/%b exp=1/2/dd/0", rsp_valid, rsp_id, rsp_result, rsp_sat);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_saturation();
    logic [7:0] va [3] = '{8'd100, 8'h80, 8'h9C};
    logic [7:0] vb [3] = '{8'd2,   8'h80, 8'd3};
    logic [7:0] vr [3] = '{8'h7F,  8'h7F, 8'h80};
    for (int k = 0; k < 3; k++) begin
      set_lane(0, va[k], vb[k]);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL sat_grant[%0d] got=%b exp=0001", k, req_ready); end
      tick();
      req_valid = 4'b0000;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== vr[k] || rsp_sat !== 1'b1) begin
        failures++;
        $display("FAIL sat_rsp[%0d] got=%b/%0d/%0h/%b exp=1/0/%0h/1", k, rsp_valid, rsp_id, rsp_result, rsp_sat, vr[k]);
      end
      tick();
      checks++;
      if (sat_count !== 16'(k + 1)) begin failures++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", k, sat_count, k + 1); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 8'(i + 1), 8'd10);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_result !== 8'(((k % 4) + 1) * 10)) begin
        failures++;
        $display("FAIL rr_rsp[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", k, rsp_valid, rsp_id, rsp_result, k % 4, ((k % 4) + 1) * 10);
      end
    end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_first_grant got=%b exp=0001", req_ready); end
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold_ready got=%b exp=0000", req_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 8'd10 || rsp_sat !== 1'b0 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b/%0d/%0d/%b/%b exp=1/0/10/0/0000", k, rsp_valid, rsp_id, rsp_result, rsp_sat, req_ready);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_grant got=%b exp=0010", req_ready); end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 8'd20) begin
      failures++; $display("FAIL bp_next_rsp got=%b/%0d/%0d exp=1/1/20", rsp_valid, rsp_id, rsp_result);
    end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_count_limit();
    do_reset();
    set_lane(0, 8'd100, 8'd2);
    req_valid = 4'b0001;
    repeat (6) tick();
    checks++;
    if (sat_count2 !== 2'd3) begin failures++; $display("FAIL cnt_stick got=%0d exp=3", sat_count2); end
    checks++;
    if (sat_count !== 16'd5) begin failures++; $display("FAIL cnt_wide got=%0d exp=5", sat_count); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++;
    if (sat_count2 !== 2'd0 || sat_count !== 16'd0) begin
      failures++; $display("FAIL cnt_clr_priority got=%0d/%0d exp=0/0", sat_count2, sat_count);
    end
    tick();
    checks++;
    if (sat_count2 !== 2'd1) begin failures++; $display("FAIL cnt_after_clr got=%0d exp=1", sat_count2); end
    req_valid = 4'h0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_round_robin();
    test_back_to_back();
    test_count_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one saturating signed multiplier among NUM_REQ requesters (PE lanes) using round-robin arbitration.
- Each requester has a valid/ready request channel.
- Results return on one registered response channel with requester ID, saturation flag and backpressure.
- A saturation event counter supports quantisation debug.

Parameters:
- bitWidth, 8, operand and result width (signed, two's complement).
- NUM_REQ, 4, number of requesters (>=2).
- CNT_W, 16, width of saturation event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*bitWidth  packed operand A; requester i at [i*bitWidth +: bitWidth].
- req_b  in  NUM_REQ*bitWidth  packed operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant; handshake completes where req_valid[i] & req_ready[i].
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  downstream accepts response.
- rsp_id  out  $clog2(NUM_REQ)  index of requester that produced rsp_result.
- rsp_result  out  bitWidth  saturated product.
- rsp_sat  out  1  product was clamped.
- sat_count  out  CNT_W  number of saturated responses accepted downstream since reset/clear.
- sat_clr  in  1  clears sat_count.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_sat=0, sat_count=0, rr_ptr=0. req_ready is combinational; it is 0 during reset because it depends on rst.
- Accept condition: slot_free = !rsp_valid | rsp_ready. This gives full throughput of one result per cycle with no bubble.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ. The first asserted index is the grant g.
  - req_ready[g]=1 only when slot_free & !rst. All other bits are 0.
  - req_ready never depends on req_a or req_b.
- Pointer: on a grant, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Arithmetic:
  - Full product p = a*b at 2*bitWidth signed.
  - If p > 2^(bitWidth-1)-1: result = 2^(bitWidth-1)-1, sat=1.
  - If p < -2^(bitWidth-1): result = -2^(bitWidth-1), sat=1.
  - Otherwise result = p[bitWidth-1:0], sat=0.
  - Comparisons are signed at full width.
  - Corner case: (-2^(bitWidth-1))*(-2^(bitWidth-1)) saturates positive.
- Latency: 1 cycle. A grant at cycle t updates the response register at t+1 with rsp_valid=1, rsp_id=g, rsp_result, rsp_sat.
- Hold rule: if rsp_valid & !rsp_ready, the response register holds and all req_ready are 0.
- Drain with no new grant: if the slot is free and there is no grant, rsp_valid <= 0. The data fields may hold stale values.
- sat_count:
  - Increments by 1 when rsp_valid & rsp_ready & rsp_sat.
  - Saturates at all-ones; it does not wrap.
  - sat_clr has priority over increment; the cleared value that cycle is 0.
- Reset mid-operation: a pending response is discarded and rr_ptr returns to 0. Requesters must re-present after reset.
- Requester rule: a requester keeps req_valid and its operands stable until granted. The block does not check this.

Decomposition:
- Shared package mult_pkg holds:
  - function sat_mul(a,b), returning {sat, result}.
  - localparams SAT_MAX/SAT_MIN, derived from bitWidth.
  - typedef of the response struct {id, result, sat}.
- Sub-module rr_arbiter (NUM_REQ; inputs req, ptr; outputs one-hot grant, grant index, any). It is reusable by the later PE scheduler.
- The multiplier is the existing saturating_multiplier module, instantiated once, or the sat_mul function.

Test Plan (bitWidth=8, NUM_REQ=4):
- Reset held 3 cycles with all req_valid=1 -> req_ready=0000, rsp_valid=0, sat_count=0.
- Only req 2 valid, a=5, b=-7, rsp_ready=1 -> req_ready=0100. Next cycle: rsp_valid=1, rsp_id=2, rsp_result=-35, rsp_sat=0.
- Saturation, one operand pair per run:
  - a=100, b=2 -> rsp_result=127, rsp_sat=1.
  - a=-128, b=-128 -> rsp_result=127, rsp_sat=1.
  - a=-100, b=3 -> rsp_result=-128, rsp_sat=1.
  - sat_count increments by 1 per saturated response accepted.
- All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles. One response per cycle with rsp_id sequence 0,1,2,3,0.
- Backpressure: rsp_ready=0 for 3 cycles while a response is pending -> rsp_* fields stable and req_ready=0000. rsp_ready=1 -> a new grant in that same cycle, with no bubble.
- Counter limit, with CNT_W=2:
  - Force 5 saturated accepts -> sat_count sticks at 3.
  - sat_clr asserted together with a saturated accept -> sat_count=0.
